ram_sdp_be: RTL and testbench
=============================

Name: ram_sdp_be

Overview:
Parametrised simple-dual-port synchronous RAM. It is the successor to the single-port ram macro.
- Independent write and read ports, so one write and one read can occur per cycle.
- Per-byte write enables.
- Selectable read latency of 1 or 2 cycles.
- Selectable read-during-write behaviour.
- Built-in clear engine that zeroes the array after reset or on request.
It sits beside the BDPU datapath as general scratch/weight storage.

Parameters:
DATA_WIDTH, 32, word width in bits; must be a multiple of 8 (elaboration $error otherwise)
ADD_WIDTH, 10, address bits
RAM_SIZE, 1<<ADD_WIDTH, number of words
READ_LATENCY, 1, cycles from accepted read to rd_valid; legal values 1 or 2 (elaboration $error otherwise)
RDW_MODE, 0, same-address read-during-write: 0 = old data, 1 = new (write-first) data

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
clr  in  1  single-cycle request to zero the whole array
busy  out  1  high while the clear engine runs; user accesses ignored
wr_cs  in  1  write-port chip select
wr_en  in  1  write enable
wr_be  in  DATA_WIDTH/8  byte enables; bit i covers data bits [8i+7:8i]
wr_add  in  ADD_WIDTH  write address
wr_data  in  DATA_WIDTH  write data
rd_cs  in  1  read-port chip select
rd_oe  in  1  read/output enable
rd_add  in  ADD_WIDTH  read address
rd_data  out  DATA_WIDTH  registered read data
rd_valid  out  1  one-cycle pulse: rd_data holds the result of a read

Behaviour:
Reset (rst_n low, asynchronous):
- rd_data=0, rd_valid=0, internal pipeline registers=0.
- FSM=CLEAR, clr_ptr=0, busy=1.
- Array contents are not reset directly; they are zeroed by the clear engine.
- Reset asserted mid-clear restarts the clear from address 0.

FSM states IDLE and CLEAR:
- CLEAR: each cycle writes 0 to memory[clr_ptr] and increments clr_ptr.
- CLEAR exits to IDLE on the cycle it writes RAM_SIZE-1.
- A clear takes exactly RAM_SIZE cycles with busy=1. busy is a registered FSM decode and falls the cycle after the last clear write.
- IDLE: clr=1 gives CLEAR with clr_ptr=0 on the next edge.
- clr during CLEAR is ignored (no restart).

Write (IDLE only):
- Accepted when wr_cs && wr_en && !busy.
- For each i with wr_be[i]=1, memory[wr_add] byte i <= wr_data byte i; other bytes are unchanged.
- wr_be=0 is a legal no-op.

Read (IDLE only):
- Accepted when rd_cs && rd_oe && !busy.
- READ_LATENCY=1: rd_data updated and rd_valid=1 on the edge after acceptance.
- READ_LATENCY=2: one additional output register stage. rd_valid is delayed to match; the pipeline is fully pipelined, with back-to-back reads every cycle.
- With no accepted read, rd_data holds its last value and rd_valid=0.

Busy rules:
- Reads and writes presented while busy=1 are dropped, with no rd_valid.
- A read already in the READ_LATENCY=2 pipeline when clr is taken still completes.

Read-during-write, same address, same cycle:
- RDW_MODE=0: returns the pre-write word.
- RDW_MODE=1: returns the merged word (enabled bytes from wr_data, other bytes old).
- Different addresses are independent.

No other hazards; no backpressure.

Test Plan:
Bench parameters ADD_WIDTH=4, DATA_WIDTH=32 unless stated.

1. Reset, release rst_n -> busy=1 for exactly 16 cycles, rd_valid never high; then read addr 0..15 -> each returns 0x00000000, rd_valid 1 cycle after each read.
2. Write 0xAABBCCDD to addr 5 with wr_be=4'b1111, then 0x11223344 with wr_be=4'b0101 -> read addr 5 returns 0xAA22CC44.
3. RDW_MODE=0 vs 1: addr 3 holds 0x0; in the same cycle write 0xDEADBEEF (be=4'b1111) and read addr 3 -> returns 0x00000000 (mode 0) / 0xDEADBEEF (mode 1); next read returns 0xDEADBEEF in both modes.
4. READ_LATENCY=2: reads of addr 1,2,3 on consecutive cycles (data 0x1,0x2,0x3) -> rd_valid high on cycles +2,+3,+4 with 0x1,0x2,0x3; rd_data holds 0x3 afterwards.
5. After filling memory with nonzero data, pulse clr -> busy rises next cycle for 16 cycles; a write to addr 7 issued mid-clear is dropped; clr re-pulsed mid-clear does not extend the clear; all addresses read 0 afterwards.
6. Assert rst_n low at clear cycle 8, release -> rd_data=0, rd_valid=0 immediately; clear restarts at addr 0 and busy lasts a full 16 cycles.

Source files
------------

// File: rtl/ram_sdp_be.sv
// ram_sdp_be: simple-dual-port synchronous RAM with byte write enables,
// selectable read latency (1 or 2), selectable same-address read-during-write
// result, and a built-in clear engine that zeroes the array after reset or on
// request.
//
// State table:
//   IDLE  | user reads/writes accepted; clr starts a clear
//   CLEAR | one word zeroed per cycle at clr_ptr; user accesses dropped
//
// Ports:
//   clk, rst_n        clock (rising edge) / async active-low reset
//   clr               single-cycle request to zero the whole array
//   busy              high while the clear engine runs
//   wr_cs, wr_en      write accepted when both high and not busy
//   wr_be             byte enables, bit i covers wr_data[8i+7:8i]
//   wr_add, wr_data   write address / data
//   rd_cs, rd_oe      read accepted when both high and not busy
//   rd_add            read address
//   rd_data, rd_valid registered read data / one-cycle result strobe
module ram_sdp_be #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADD_WIDTH    = 10,
    parameter int RAM_SIZE     = 1 << ADD_WIDTH,
    parameter int READ_LATENCY = 1,
    parameter int RDW_MODE     = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    output logic                    busy,
    input  logic                    wr_cs,
    input  logic                    wr_en,
    input  logic [DATA_WIDTH/8-1:0] wr_be,
    input  logic [ADD_WIDTH-1:0]    wr_add,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic                    rd_cs,
    input  logic                    rd_oe,
    input  logic [ADD_WIDTH-1:0]    rd_add,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_valid
);

    localparam int NUM_BYTES = DATA_WIDTH / 8;
    localparam logic [ADD_WIDTH-1:0] LAST_ADD = ADD_WIDTH'(RAM_SIZE - 1);

    if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH == 0) begin : g_bad_width
        $error("ram_sdp_be: DATA_WIDTH must be a non-zero multiple of 8");
    end
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $error("ram_sdp_be: READ_LATENCY must be 1 or 2");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t                 state, state_nxt;
    logic [ADD_WIDTH-1:0]   clr_ptr, clr_ptr_nxt;
    logic                   wr_acc, rd_acc;
    logic [DATA_WIDTH-1:0]  mem [RAM_SIZE];
    logic [DATA_WIDTH-1:0]  rd_word;

    // ---------------- clear engine FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= CLEAR;
            clr_ptr <= '0;
            busy    <= 1'b1;
        end else begin
            state   <= state_nxt;
            clr_ptr <= clr_ptr_nxt;
            busy    <= (state_nxt == CLEAR);
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_ptr_nxt = clr_ptr;
        case (state)
            IDLE: begin
                if (clr) begin
                    state_nxt   = CLEAR;
                    clr_ptr_nxt = '0;
                end
            end
            CLEAR: begin
                // clr is deliberately not looked at here: no restart mid-clear
                clr_ptr_nxt = clr_ptr + 1'b1;
                if (clr_ptr == LAST_ADD) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt   = CLEAR;
                clr_ptr_nxt = '0;
            end
        endcase
    end

    assign wr_acc = wr_cs && wr_en && !busy;
    assign rd_acc = rd_cs && rd_oe && !busy;

    // ---------------- array ----------------
    // busy tracks state==CLEAR exactly, so clear and user writes never collide.
    always_ff @(posedge clk) begin
        if (busy) begin
            mem[clr_ptr] <= '0;
        end else if (wr_acc) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (wr_be[i]) begin
                    mem[wr_add][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    // Same-address write-first bypass merges only the enabled bytes.
    always_comb begin
        rd_word = mem[rd_add];
        if (RDW_MODE == 1 && wr_acc && (wr_add == rd_add)) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (wr_be[i]) begin
                    rd_word[8*i +: 8] = wr_data[8*i +: 8];
                end
            end
        end
    end

    // ---------------- read pipeline ----------------
    // The pipeline keeps draining while busy, so a read accepted just before
    // a clear still delivers its result.
    if (READ_LATENCY == 2) begin : g_lat2
        logic [DATA_WIDTH-1:0] s1_data;
        logic                  s1_valid;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s1_data  <= '0;
                s1_valid <= 1'b0;
                rd_data  <= '0;
                rd_valid <= 1'b0;
            end else begin
                s1_valid <= rd_acc;
                if (rd_acc) begin
                    s1_data <= rd_word;
                end
                rd_valid <= s1_valid;
                if (s1_valid) begin
                    rd_data <= s1_data;
                end
            end
        end
    end else begin : g_lat1
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_data  <= '0;
                rd_valid <= 1'b0;
            end else begin
                rd_valid <= rd_acc;
                if (rd_acc) begin
                    rd_data <= rd_word;
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_sdp_be.sv
module tb_ram_sdp_be;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int BW = DW / 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clr;
    logic          wr_cs, wr_en;
    logic [BW-1:0] wr_be;
    logic [AW-1:0] wr_add;
    logic [DW-1:0] wr_data;
    logic          rd_cs, rd_oe;
    logic [AW-1:0] rd_add;

    // u0: latency 1 old-data, u1: latency 1 write-first, u2: latency 2 old-data
    logic          busy0, busy1, busy2;
    logic [DW-1:0] rd_data0, rd_data1, rd_data2;
    logic          rd_valid0, rd_valid1, rd_valid2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ram_sdp_be #(.DATA_WIDTH(DW), .ADD_WIDTH(AW), .READ_LATENCY(1), .RDW_MODE(0)) u0 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .busy(busy0),
        .wr_cs(wr_cs), .wr_en(wr_en), .wr_be(wr_be), .wr_add(wr_add), .wr_data(wr_data),
        .rd_cs(rd_cs), .rd_oe(rd_oe), .rd_add(rd_add), .rd_data(rd_data0), .rd_valid(rd_valid0));

    ram_sdp_be #(.DATA_WIDTH(DW), .ADD_WIDTH(AW), .READ_LATENCY(1), .RDW_MODE(1)) u1 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .busy(busy1),
        .wr_cs(wr_cs), .wr_en(wr_en), .wr_be(wr_be), .wr_add(wr_add), .wr_data(wr_data),
        .rd_cs(rd_cs), .rd_oe(rd_oe), .rd_add(rd_add), .rd_data(rd_data1), .rd_valid(rd_valid1));

    ram_sdp_be #(.DATA_WIDTH(DW), .ADD_WIDTH(AW), .READ_LATENCY(2), .RDW_MODE(0)) u2 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .busy(busy2),
        .wr_cs(wr_cs), .wr_en(wr_en), .wr_be(wr_be), .wr_add(wr_add), .wr_data(wr_data),
        .rd_cs(rd_cs), .rd_oe(rd_oe), .rd_add(rd_add), .rd_data(rd_data2), .rd_valid(rd_valid2));

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        clr = 1'b0; wr_cs = 1'b0; wr_en = 1'b0; wr_be = '0; wr_add = '0; wr_data = '0;
        rd_cs = 1'b0; rd_oe = 1'b0; rd_add = '0;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] be);
        wr_cs = 1'b1; wr_en = 1'b1; wr_add = a; wr_data = d; wr_be = be;
        tick();
        wr_cs = 1'b0; wr_en = 1'b0; wr_be = '0;
    endtask

    // latency-1 read, checked on both latency-1 instances
    task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string tag);
        rd_cs = 1'b1; rd_oe = 1'b1; rd_add = a;
        tick();
        rd_cs = 1'b0; rd_oe = 1'b0;
        chk({tag, "_v0"}, DW'(rd_valid0), DW'(1'b1));
        chk({tag, "_d0"}, rd_data0, exp);
        chk({tag, "_v1"}, DW'(rd_valid1), DW'(1'b1));
        chk({tag, "_d1"}, rd_data1, exp);
    endtask

    int  cnt;
    logic saw_valid;

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        tick(); tick();

        // ---- 1: reset state, post-reset clear, all zero ----
        chk("rst_busy", DW'(busy0), DW'(1'b1));
        chk("rst_rdv0", DW'(rd_valid0), DW'(1'b0));
        chk("rst_rdd0", rd_data0, '0);
        chk("rst_rdd2", rd_data2, '0);
        rst_n = 1'b1;
        rd_cs = 1'b1; rd_oe = 1'b1; rd_add = 4'd9;   // must be dropped while busy
        cnt = 0; saw_valid = 1'b0;
        while (busy0 && cnt < 100) begin
            tick();
            cnt++;
            if (rd_valid0 || rd_valid1 || rd_valid2) saw_valid = 1'b1;
        end
        rd_cs = 1'b0; rd_oe = 1'b0;
        chk("init_clear_cycles", DW'(cnt), DW'(16));
        chk("init_no_valid", DW'(saw_valid), DW'(1'b0));
        for (int i = 0; i < 16; i++) do_read(AW'(i), 32'h0, "init_zero");
        tick();
        chk("idle_no_valid", DW'(rd_valid0), DW'(1'b0));

        // ---- 2: byte enables ----
        do_write(4'd5, 32'hAABBCCDD, 4'b1111);
        do_write(4'd5, 32'h11223344, 4'b0101);
        do_read(4'd5, 32'hAA22CC44, "be_merge");
        do_write(4'd5, 32'h00000000, 4'b0000);
        wr_cs = 1'b1; wr_en = 1'b0; wr_be = 4'b1111; wr_data = 32'h0; wr_add = 4'd5;
        tick();
        wr_cs = 1'b0; wr_be = '0;
        do_read(4'd5, 32'hAA22CC44, "be_noop");
        tick();
        chk("hold_data", rd_data0, 32'hAA22CC44);
        chk("hold_novalid", DW'(rd_valid0), DW'(1'b0));

        // ---- 3: read-during-write ----
        wr_cs = 1'b1; wr_en = 1'b1; wr_add = 4'd3; wr_data = 32'hDEADBEEF; wr_be = 4'b1111;
        rd_cs = 1'b1; rd_oe = 1'b1; rd_add = 4'd3;
        tick();
        idle_inputs();
        chk("rdw_mode0", rd_data0, 32'h00000000);
        chk("rdw_mode1", rd_data1, 32'hDEADBEEF);
        do_read(4'd3, 32'hDEADBEEF, "rdw_after");
        wr_cs = 1'b1; wr_en = 1'b1; wr_add = 4'd4; wr_data = 32'h12345678; wr_be = 4'b0011;
        rd_cs = 1'b1; rd_oe = 1'b1; rd_add = 4'd4;
        tick();
        idle_inputs();
        chk("rdw_part_m0", rd_data0, 32'h00000000);
        chk("rdw_part_m1", rd_data1, 32'h00005678);
        wr_cs = 1'b1; wr_en = 1'b1; wr_add = 4'd6; wr_data = 32'h55555555; wr_be = 4'b1111;
        rd_cs = 1'b1; rd_oe = 1'b1; rd_add = 4'd5;
        tick();
        idle_inputs();
        chk("rdw_diff_m0", rd_data0, 32'hAA22CC44);
        chk("rdw_diff_m1", rd_data1, 32'hAA22CC44);

        // ---- 4: latency 2 back-to-back ----
        do_write(4'd1, 32'h1, 4'b1111);
        do_write(4'd2, 32'h2, 4'b1111);
        do_write(4'd3, 32'h3, 4'b1111);
        tick();
        rd_cs = 1'b1; rd_oe = 1'b1; rd_add = 4'd1;
        tick();
        chk("l2_c1_v", DW'(rd_valid2), DW'(1'b0));
        chk("l1_c1_d", rd_data0, 32'h1);
        rd_add = 4'd2;
        tick();
        chk("l2_c2_v", DW'(rd_valid2), DW'(1'b1));
        chk("l2_c2_d", rd_data2, 32'h1);
        rd_add = 4'd3;
        tick();
        rd_cs = 1'b0; rd_oe = 1'b0;
        chk("l2_c3_v", DW'(rd_valid2), DW'(1'b1));
        chk("l2_c3_d", rd_data2, 32'h2);
        tick();
        chk("l2_c4_v", DW'(rd_valid2), DW'(1'b1));
        chk("l2_c4_d", rd_data2, 32'h3);
        tick();
        chk("l2_c5_v", DW'(rd_valid2), DW'(1'b0));
        chk("l2_c5_d", rd_data2, 32'h3);

        // ---- 5: clear on request ----
        for (int i = 0; i < 16; i++) do_write(AW'(i), 32'h01010101 * (i + 1), 4'b1111);
        do_read(4'd7, 32'h08080808, "fill_chk");
        chk("pre_clr_busy", DW'(busy0), DW'(1'b0));
        clr = 1'b1; rd_cs = 1'b1; rd_oe = 1'b1; rd_add = 4'd1;
        tick();
        idle_inputs();
        chk("clr_busy_rise", DW'(busy0), DW'(1'b1));
        chk("clr_inflight_l1", rd_data0, 32'h02020202);
        tick();
        chk("clr_inflight_l2v", DW'(rd_valid2), DW'(1'b1));
        chk("clr_inflight_l2d", rd_data2, 32'h02020202);
        cnt = 2;
        while (busy0 && cnt < 100) begin
            if (cnt == 5) clr = 1'b1;
            if (cnt == 10) begin
                wr_cs = 1'b1; wr_en = 1'b1; wr_add = 4'd7; wr_data = 32'hFFFFFFFF; wr_be = 4'b1111;
            end
            tick();
            idle_inputs();
            if (busy0) cnt++;
        end
        chk("clr_cycles", DW'(cnt), DW'(16));
        for (int i = 0; i < 16; i++) do_read(AW'(i), 32'h0, "clr_zero");

        // ---- 6: reset mid-clear ----
        do_write(4'd2, 32'hCAFEF00D, 4'b1111);
        do_write(4'd14, 32'h0BADF00D, 4'b1111);
        do_read(4'd2, 32'hCAFEF00D, "pre_rst");
        tick();
        chk("pre_rst_l2", rd_data2, 32'hCAFEF00D);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_d0", rd_data0, '0);
        chk("mid_rst_d2", rd_data2, '0);
        chk("mid_rst_v0", DW'(rd_valid0), DW'(1'b0));
        chk("mid_rst_busy", DW'(busy0), DW'(1'b1));
        tick(); tick();
        rst_n = 1'b1;
        cnt = 0;
        while (busy0 && cnt < 100) begin
            tick();
            cnt++;
        end
        chk("rst_clear_cycles", DW'(cnt), DW'(16));
        do_read(4'd2, 32'h0, "rst_zero2");
        do_read(4'd14, 32'h0, "rst_zero14");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
